// File: rtl/trivium_host_if_if.sv
// Bus-side handshake bundle for trivium_host_if: key/IV load, plaintext in, ciphertext out.
// The slave modport is the host-if block; the master modport is the producer/consumer.
interface trivium_host_if_if;
  logic [79:0] key_i;
  logic [79:0] iv_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [31:0] din_i;
  logic        din_last_i;
  logic        din_valid_i;
  logic        din_ready_o;
  logic [31:0] dout_o;
  logic        dout_valid_o;
  logic        dout_ready_i;

  modport slave (
    input  key_i, iv_i, key_valid_i, din_i, din_last_i, din_valid_i, dout_ready_i,
    output key_ready_o, din_ready_o, dout_o, dout_valid_o
  );

  modport master (
    output key_i, iv_i, key_valid_i, din_i, din_last_i, din_valid_i, dout_ready_i,
    input  key_ready_o, din_ready_o, dout_o, dout_valid_o
  );
endinterface

// File: rtl/trivium_host_if.sv
// Host-side initiator for the serial trivium_top core: serializes key/IV and
// plaintext words LSB-first and collects the returned ciphertext words.
module trivium_host_if #(
  parameter int INIT_TO = 4095
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  trivium_host_if_if.slave  bus,
  output logic              busy_o,
  output logic              err_o,
  output logic              triv_dat_o,
  output logic              triv_get_dat_o,
  output logic              triv_ld_keys_o,
  output logic              triv_end_o,
  input  logic              triv_dat_i,
  input  logic              triv_ready_i
);

  localparam int TO_W = (INIT_TO > 0) ? $clog2(INIT_TO + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_KEY, S_IV, S_LOAD, S_INIT, S_WAITW, S_LEAD, S_WORD, S_OUT, S_END, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [79:0]       key_sr, iv_sr;
  logic [31:0]       word_sr, out_sr;
  logic              last_r;
  logic [6:0]        bit_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic key_hs, din_hs, dout_hs;
  logic key_ready, din_ready, dout_valid;

  assign key_hs  = (state_q == S_IDLE)  && bus.key_valid_i;
  assign din_hs  = (state_q == S_WAITW) && bus.din_valid_i;
  assign dout_hs = (state_q == S_OUT)   && bus.dout_ready_i;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (key_hs) state_d = S_KEY;
      S_KEY:   if (bit_cnt == 7'd79) state_d = S_IV;
      S_IV:    if (bit_cnt == 7'd79) state_d = S_LOAD;
      S_LOAD:  state_d = S_INIT;
      S_INIT: begin
        if (triv_ready_i)                     state_d = S_WAITW;
        else if (to_cnt == TO_W'(INIT_TO))    state_d = S_ERR;
      end
      S_WAITW: if (din_hs) state_d = S_LEAD;
      S_LEAD:  state_d = S_WORD;
      S_WORD:  if (bit_cnt == 7'd31) state_d = S_OUT;
      S_OUT:   if (dout_hs) state_d = last_r ? S_END : S_WAITW;
      S_END:   state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Pure Moore decode: nothing here looks at an input, so the core and the
  // bus never see a combinational path through this block.
  always_comb begin
    key_ready      = 1'b0;
    din_ready      = 1'b0;
    dout_valid     = 1'b0;
    triv_dat_o     = 1'b0;
    triv_get_dat_o = 1'b0;
    triv_ld_keys_o = 1'b0;
    triv_end_o     = 1'b0;
    case (state_q)
      S_IDLE:  key_ready = 1'b1;
      S_KEY: begin
        triv_get_dat_o = 1'b1;
        triv_dat_o     = key_sr[0];
      end
      S_IV: begin
        triv_get_dat_o = 1'b1;
        triv_dat_o     = iv_sr[0];
        triv_ld_keys_o = (bit_cnt == 7'd79);
      end
      S_LOAD:  triv_get_dat_o = 1'b1;
      S_WAITW: din_ready = 1'b1;
      S_LEAD:  triv_get_dat_o = 1'b1;
      S_WORD: begin
        triv_get_dat_o = 1'b1;
        triv_dat_o     = word_sr[0];
      end
      S_OUT:   dout_valid = 1'b1;
      S_END:   triv_end_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.key_ready_o  = key_ready;
  assign bus.din_ready_o  = din_ready;
  assign bus.dout_valid_o = dout_valid;
  assign bus.dout_o       = out_sr;
  assign busy_o           = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err_o            = (state_q == S_ERR);

  // One bit counter serves KEY, IV and WORD; each state exits on its own
  // terminal count so the counter never wraps.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      key_sr  <= '0;
      iv_sr   <= '0;
      word_sr <= '0;
      out_sr  <= '0;
      last_r  <= 1'b0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_hs) begin
            key_sr  <= bus.key_i;
            iv_sr   <= bus.iv_i;
            bit_cnt <= '0;
          end
        end
        S_KEY: begin
          key_sr  <= {1'b0, key_sr[79:1]};
          bit_cnt <= (bit_cnt == 7'd79) ? 7'd0 : bit_cnt + 7'd1;
        end
        S_IV: begin
          iv_sr   <= {1'b0, iv_sr[79:1]};
          bit_cnt <= (bit_cnt == 7'd79) ? 7'd0 : bit_cnt + 7'd1;
        end
        S_LOAD:  to_cnt <= '0;
        S_INIT: begin
          if (to_cnt != TO_W'(INIT_TO)) to_cnt <= to_cnt + 1'b1;
        end
        S_WAITW: begin
          if (din_hs) begin
            word_sr <= bus.din_i;
            last_r  <= bus.din_last_i;
          end
        end
        S_LEAD:  bit_cnt <= '0;
        S_WORD: begin
          word_sr <= {1'b0, word_sr[31:1]};
          out_sr  <= {triv_dat_i, out_sr[31:1]};
          if (bit_cnt != 7'd31) bit_cnt <= bit_cnt + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/trivium_host_if.md
# trivium_host_if

Synthesizable host-side initiator for the serial `trivium_top` protocol. It accepts a parallel 80-bit key/IV pair and 32-bit plaintext words over valid/ready handshakes. It serializes them LSB-first onto the core's bit interface and returns the 32-bit ciphertext words. It sits between a bus-side producer/consumer and `trivium_top`, and replaces bench-only drivers in silicon.

## Interface
- `INIT_TO`, default 4095: maximum number of cycles spent in INIT waiting for `triv_ready_i` before the block flags an error.
- `clk_i` in 1: clock, rising edge.
- `n_rst_i` in 1: reset, asynchronous, active-low.
- `key_i` in 80: key, captured on key handshake.
- `iv_i` in 80: IV, captured on key handshake.
- `key_valid_i` in 1 / `key_ready_o` out 1: key/IV handshake.
- `din_i` in 32: plaintext word.
- `din_last_i` in 1: marks the last word of the message.
- `din_valid_i` in 1 / `din_ready_o` out 1: plaintext handshake.
- `dout_o` out 32: ciphertext word.
- `dout_valid_o` out 1 / `dout_ready_i` in 1: ciphertext handshake.
- `busy_o` out 1: high in every state except IDLE and ERR.
- `err_o` out 1: sticky INIT timeout flag.
- `triv_dat_o`, `triv_get_dat_o`, `triv_ld_keys_o`, `triv_end_o` out 1 each: drive the core's `dat_i`, `get_dat_i`, `ld_keys_i`, `end_i`.
- `triv_dat_i`, `triv_ready_i` in 1 each: driven by the core's `dat_o`, `ready_o`.

## Operation
- Handshake transfers occur on a rising edge with valid and ready both high.
- The FSM states are IDLE, KEY, IV, LOAD, INIT, WAITW, LEAD, WORD, OUT, END, ERR.
- IDLE:
  - `key_ready_o`=1.
  - On key handshake, load the key and IV shift registers and clear the bit counter, then go to KEY.
- KEY:
  - 80 cycles with `triv_get_dat_o`=1 and `triv_dat_o`=key_sr[0].
  - Shift right with zero fill each cycle.
  - Go to IV when the counter reaches 79, and reset the counter.
- IV:
  - 80 cycles, same rules using iv_sr.
  - `triv_ld_keys_o`=1 only on the cycle where the counter equals 79.
  - Then go to LOAD.
- LOAD: 1 cycle with `triv_get_dat_o`=1 and `triv_dat_o`=0, then go to INIT.
- INIT:
  - `triv_get_dat_o`=0. A timeout counter increments each cycle.
  - If `triv_ready_i`=1, go to WAITW.
  - Else, if the counter equals `INIT_TO`, go to ERR.
- WAITW:
  - `din_ready_o`=1.
  - On handshake, capture `din_i` into word_sr and `din_last_i` into last_r, then go to LEAD.
- LEAD: 1 cycle with `triv_get_dat_o`=1 and `triv_dat_o`=0 (pipeline prime), then go to WORD.
- WORD:
  - 32 cycles with `triv_get_dat_o`=1 and `triv_dat_o`=word_sr[0].
  - Each edge: word_sr shifts right with zero fill, and out_sr <= {`triv_dat_i`, out_sr[31:1]}.
  - After counter 31, go to OUT.
- OUT:
  - `dout_valid_o`=1 and `dout_o`=out_sr, held stable until the handshake.
  - On handshake: if last_r=1, go to END; otherwise go to WAITW.
- END: 1 cycle with `triv_end_o`=1 and `triv_get_dat_o`=0, then go to IDLE.
- ERR:
  - `err_o`=1 and all `triv_*` outputs are 0. All ready outputs are 0.
  - ERR is left only by reset.
- `triv_get_dat_o` is 0 in all states not listed above as asserting it. The core holds its state while `triv_get_dat_o`=0, so gaps in WAITW/OUT are legal and of unbounded length.
- Counters:
  - The bit counter is 7 bits and is reused by KEY, IV and WORD.
  - The timeout counter is wide enough to hold `INIT_TO`.
  - No counter wraps: each state exits at its terminal count.
- Handshakes arriving outside the accepting state are ignored. The producer holds valid high until the block accepts.
- `din_last_i` is sampled only on the din handshake.

## Timing
- Reset (asynchronous, active-low):
  - FSM goes to IDLE; all shift registers and counters clear to 0.
  - `dout_o`=0; `dout_valid_o`, `din_ready_o`, `busy_o`, `err_o` and all `triv_*` outputs are 0.
  - `key_ready_o`=1, decoded from IDLE.
- Reset mid-operation returns the block to IDLE immediately. The core must be reset by the same signal.
- All outputs are Moore decodes of state, counter and registers; none depends combinationally on an input.
- Key handshake at edge T:
  - KEY occupies cycles T+1..T+80; IV occupies T+81..T+160.
  - `triv_ld_keys_o` is high in cycle T+160; LOAD is cycle T+161; INIT starts at T+162.
- `triv_ready_i` sampled high at edge R: `din_ready_o` is high from cycle R+1.
- Word handshake at edge W:
  - LEAD is cycle W+1; WORD occupies W+2..W+33.
  - out_sr bit i is captured on the edge closing word cycle i.
  - `dout_valid_o` rises in cycle W+34.
- Minimum per-word period is 35 cycles: 1 WAITW, 1 LEAD, 32 WORD, 1 OUT.
- With `dout_ready_i` held low, the block stays in OUT with `dout_o` stable and `triv_get_dat_o`=0.

## Test plan
- Serialization: key=80'h0000_0000_0000_0000_0001, iv=80'h8000_0000_0000_0000_0000.
  - `triv_dat_o`=1 only in KEY bit 0 and in IV bit 79.
  - `triv_get_dat_o` is high for exactly 161 cycles; `triv_ld_keys_o` is a single pulse at T+160.
- Encrypt: the core stub asserts ready 1152 cycles after ld_keys and returns keystream 32'hFFFF_FFFF; din=32'hA5A5_0F0F, last=1.
  - Expect `dout_o`=32'h5A5A_F0F0 in cycle W+34.
  - After the dout handshake, expect a one-cycle `triv_end_o` and then `key_ready_o`=1.
- Multi-word back-pressure: three words 32'h0000_0001, 32'h8000_0000, 32'h1234_5678 with stub keystream 0, and `dout_ready_i` low for 10 cycles on word 2.
  - Outputs equal the inputs, in order.
  - No `triv_get_dat_o` activity occurs during the stall.
- Timeout: `INIT_TO`=15 and the stub never asserts ready.
  - `err_o` rises 16 cycles after INIT entry and stays high.
  - All ready outputs stay 0 until reset.
- Reset mid-WORD: assert `n_rst_i` low at word bit 17.
  - All outputs take reset values asynchronously.
  - After release, a fresh key/IV sequence completes correctly.
- Ignored handshakes: pulse `din_valid_i` during KEY and `key_valid_i` during WORD. Neither has any effect on state or outputs.
